// File: rtl/pulpino_boot_pkg.sv
// Shared types and width helpers for the pulpino boot/reset sequencer.
package pulpino_boot_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } boot_state_e;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

  // Stage counter runs 0..STAGE_DELAY-1.
  function automatic int unsigned dly_w(input int unsigned stage_delay);
    return cnt_w(stage_delay - 1);
  endfunction

  // Domain index runs 0..NB_DOMAINS-1.
  function automatic int unsigned idx_w(input int unsigned nb_domains);
    return cnt_w(nb_domains - 1);
  endfunction

  // Lock timeout counter runs 0..LOCK_TIMEOUT-1.
  function automatic int unsigned tmo_w(input int unsigned lock_timeout);
    return cnt_w(lock_timeout - 1);
  endfunction

  // Software-reset hold counter is loaded with STAGE_DELAY.
  function automatic int unsigned hold_w(input int unsigned stage_delay);
    return cnt_w(stage_delay);
  endfunction

endpackage

// File: rtl/pulpino_boot_sync.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module pulpino_boot_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pulpino_boot_seq.sv
// Boot and reset sequencer: waits for FLL lock (with timeout), releases the
// reset domains one by one, then gates core fetch and services per-domain
// software resets.
// Optional feature: define PULPINO_BOOT_LOCK_LOSS_RST_EN to re-enter the
// boot sequence when lock is lost while running.
module pulpino_boot_seq
  import pulpino_boot_pkg::*;
#(
  parameter int unsigned NB_DOMAINS   = 3,
  parameter int unsigned STAGE_DELAY  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  testmode_i,
  input  logic                  fll_lock_i,
  input  logic                  fetch_enable_i,
  input  logic [NB_DOMAINS-1:0] sw_rst_req_i,
  output logic [NB_DOMAINS-1:0] domain_rstn_o,
  output logic                  fetch_enable_o,
  output logic                  boot_done_o,
  output logic                  lock_timeout_o,
  output logic                  lock_lost_o,
  output logic [1:0]            state_o
);

  localparam int unsigned DLY_W  = dly_w(STAGE_DELAY);
  localparam int unsigned IDX_W  = idx_w(NB_DOMAINS);
  localparam int unsigned TMO_W  = tmo_w(LOCK_TIMEOUT);
  localparam int unsigned HOLD_W = hold_w(STAGE_DELAY);

  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NB_DOMAINS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(STAGE_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  boot_state_e           r_state;
  logic [TMO_W-1:0]      r_tmo;
  logic [DLY_W-1:0]      r_dly;
  logic [IDX_W-1:0]      r_idx;
  logic [HOLD_W-1:0]     r_hold [NB_DOMAINS];
  logic [NB_DOMAINS-1:0] r_dom;
  logic                  r_fetch;
  logic                  r_done;
  logic                  r_tmo_flag;
  logic                  r_lost;
  logic                  r_lock_prev;
  logic                  w_lock;
  logic                  w_lock_fall;
  logic                  w_abort;

  pulpino_boot_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (fll_lock_i),
    .o_q     (w_lock)
  );

  assign w_lock_fall = (r_state == ST_RUN) && r_lock_prev && !w_lock;

`ifdef PULPINO_BOOT_LOCK_LOSS_RST_EN
  assign w_abort = w_lock_fall;
`else
  assign w_abort = 1'b0;
`endif

  // Sequencer FSM: lock wait, staged release, then run-time fetch gating and
  // per-domain software-reset hold counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_tmo       <= '0;
      r_dly       <= '0;
      r_idx       <= '0;
      r_dom       <= '0;
      r_fetch     <= 1'b0;
      r_done      <= 1'b0;
      r_tmo_flag  <= 1'b0;
      r_lost      <= 1'b0;
      r_lock_prev <= 1'b0;
      for (int unsigned k = 0; k < NB_DOMAINS; k++) r_hold[k] <= '0;
    end else begin
      r_lock_prev <= w_lock;
      if (w_lock_fall) r_lost <= 1'b1;

      case (r_state)
        ST_RESET: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT_LOCK;
        end

        ST_WAIT_LOCK: begin
          r_tmo <= r_tmo + 1'b1;
          r_dly <= '0;
          r_idx <= '0;
          if (w_lock) begin
            r_state <= ST_RELEASE;
          end else if (r_tmo == TMO_LAST) begin
            r_tmo_flag <= 1'b1;
            r_state    <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (r_dly == DLY_LAST) begin
            r_dly        <= '0;
            r_dom[r_idx] <= 1'b1;
            r_idx        <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) begin
              r_done  <= 1'b1;
              r_state <= ST_RUN;
            end
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end

        ST_RUN: begin
          if (w_abort) begin
            r_dom   <= '0;
            r_fetch <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_WAIT_LOCK;
            for (int unsigned k = 0; k < NB_DOMAINS; k++) r_hold[k] <= '0;
          end else begin
            // A fresh request on domain 0 blocks fetch on the same edge it
            // pulls the domain low, so fetch never overlaps the held window.
            r_fetch <= fetch_enable_i & r_done & r_dom[0] & ~sw_rst_req_i[0];
            for (int unsigned k = 0; k < NB_DOMAINS; k++) begin
              if (sw_rst_req_i[k]) begin
                r_dom[k]  <= 1'b0;
                r_hold[k] <= HOLD_INIT;
              end else if (r_hold[k] != '0) begin
                r_hold[k] <= r_hold[k] - 1'b1;
                if (r_hold[k] == HOLD_ONE) r_dom[k] <= 1'b1;
              end
            end
          end
        end

        default: r_state <= ST_RESET;
      endcase
    end
  end

  assign domain_rstn_o  = testmode_i ? {NB_DOMAINS{rst_n}} : r_dom;
  assign fetch_enable_o = testmode_i ? fetch_enable_i : r_fetch;
  assign boot_done_o    = r_done;
  assign lock_timeout_o = r_tmo_flag;
  assign lock_lost_o    = r_lost;
  assign state_o        = r_state;

endmodule

// File: tb/tb_pulpino_boot_seq.sv
// Self-checking bench for pulpino_boot_seq: timestamp-based reference model,
// per-cycle compare, directed literal checks and a randomized run phase.
module tb_pulpino_boot_seq;

  localparam int NB = 3;
  localparam int SD = 16;
  localparam int LT = 1024;
  localparam int S  = 2;
`ifdef PULPINO_BOOT_LOCK_LOSS_RST_EN
  localparam bit LOSS_RST = 1'b1;
`else
  localparam bit LOSS_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          testmode_i = 1'b0;
  logic          fll_lock_i = 1'b0;
  logic          fetch_enable_i = 1'b0;
  logic [NB-1:0] sw_rst_req_i = '0;
  logic [NB-1:0] domain_rstn_o;
  logic          fetch_enable_o;
  logic          boot_done_o;
  logic          lock_timeout_o;
  logic          lock_lost_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pulpino_boot_seq #(
    .NB_DOMAINS   (NB),
    .STAGE_DELAY  (SD),
    .LOCK_TIMEOUT (LT),
    .SYNC_STAGES  (S)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .testmode_i     (testmode_i),
    .fll_lock_i     (fll_lock_i),
    .fetch_enable_i (fetch_enable_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .domain_rstn_o  (domain_rstn_o),
    .fetch_enable_o (fetch_enable_o),
    .boot_done_o    (boot_done_o),
    .lock_timeout_o (lock_timeout_o),
    .lock_lost_o    (lock_lost_o),
    .state_o        (state_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model (edge timestamps) ----------------
  int      mn;                // clock edges seen since reset release
  bit      lock_s[$];         // fll_lock_i sampled at each edge
  int      ph;                // expected state_o value
  int      wait_start, rel_entry;
  int      held_until [NB];   // domain k is low after edge e while e < held_until[k]
  bit      m_tmo, m_lost, m_done, m_fetch;
  bit [NB-1:0] m_dom;

  function automatic bit synced_at(input int e);
    if (e < 0) return 1'b0;
    return lock_s[e];
  endfunction

  task automatic model_reset();
    mn = 0; lock_s.delete(); ph = 0; wait_start = 0; rel_entry = -1;
    m_tmo = 0; m_lost = 0; m_done = 0; m_fetch = 0; m_dom = '0;
    for (int k = 0; k < NB; k++) held_until[k] = -1;
  endtask

  task automatic model_step();
    int e;
    bit fall;
    e = mn;
    lock_s.push_back(fll_lock_i);
    fall = synced_at(e - 1 - S) && !synced_at(e - S);
    case (ph)
      0: begin ph = 1; wait_start = e; end
      1: begin
        if (synced_at(e - S)) begin ph = 2; rel_entry = e; end
        else if (e - wait_start == LT) begin m_tmo = 1; ph = 2; rel_entry = e; end
      end
      2: begin
        for (int k = 0; k < NB; k++) m_dom[k] = (e - rel_entry >= SD * (k + 1));
        if (e - rel_entry == SD * NB) begin ph = 3; m_done = 1; end
      end
      default: begin
        if (fall) m_lost = 1;
        if (fall && LOSS_RST) begin
          ph = 1; wait_start = e; m_dom = '0; m_done = 0; m_fetch = 0;
          for (int k = 0; k < NB; k++) held_until[k] = -1;
        end else begin
          for (int k = 0; k < NB; k++) begin
            if (sw_rst_req_i[k]) held_until[k] = e + SD;
            m_dom[k] = (e >= held_until[k]);
          end
          m_fetch = fetch_enable_i && (e > held_until[0]);
        end
      end
    endcase
    mn = e + 1;
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NB-1:0] edom;
    logic          efe;
    edom = testmode_i ? {NB{rst_n}} : m_dom;
    efe  = testmode_i ? fetch_enable_i : m_fetch;
    chk("cyc_domain_rstn", 32'(domain_rstn_o), 32'(edom));
    chk("cyc_fetch_en",    32'(fetch_enable_o), 32'(efe));
    chk("cyc_boot_done",   32'(boot_done_o), 32'(m_done));
    chk("cyc_lock_tmo",    32'(lock_timeout_o), 32'(m_tmo));
    chk("cyc_lock_lost",   32'(lock_lost_o), 32'(m_lost));
    chk("cyc_state",       32'(state_o), 32'(ph));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_edge(input int e);
    int g;
    g = 0;
    while (mn < e + 1 && g < 5000) begin @(negedge clk); #1; g++; end
    if (mn < e + 1) chk("wait_edge_timeout", 32'(mn), 32'(e + 1));
  endtask

  task automatic wait_run();
    int g;
    g = 0;
    while (ph != 3 && g < 3000) begin step(); g++; end
    chk("reach_run_state", 32'(state_o), 32'd3);
  endtask

  task automatic boot_checks(input string tag);
    wait_edge(1);  chk({tag, "_state_wait"}, 32'(state_o), 32'd1);
    wait_edge(2);  chk({tag, "_state_rel"},  32'(state_o), 32'd2);
                   chk({tag, "_model_rel_entry"}, 32'(rel_entry), 32'd2);
    wait_edge(17); chk({tag, "_dom_e17"}, 32'(domain_rstn_o), 32'b000);
    wait_edge(18); chk({tag, "_dom_e18"}, 32'(domain_rstn_o), 32'b001);
    wait_edge(34); chk({tag, "_dom_e34"}, 32'(domain_rstn_o), 32'b011);
    wait_edge(49); chk({tag, "_done_e49"}, 32'(boot_done_o), 32'd0);
    wait_edge(50); chk({tag, "_dom_e50"}, 32'(domain_rstn_o), 32'b111);
                   chk({tag, "_done_e50"}, 32'(boot_done_o), 32'd1);
                   chk({tag, "_state_run"}, 32'(state_o), 32'd3);
                   chk({tag, "_no_tmo"}, 32'(lock_timeout_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [NB-1:0] r;

    // Reset values
    repeat (3) step();
    chk("rst_dom",   32'(domain_rstn_o), 32'd0);
    chk("rst_fetch", 32'(fetch_enable_o), 32'd0);
    chk("rst_done",  32'(boot_done_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);

    // Boot with lock already high
    fll_lock_i = 1'b1; fetch_enable_i = 1'b1; rst_n = 1'b1;
    boot_checks("boot1");
    wait_edge(51); chk("fetch_after_boot", 32'(fetch_enable_o), 32'd1);

    // Software reset on domains 0 and 2
    step(); e = mn; sw_rst_req_i = 3'b101; step(); sw_rst_req_i = '0;
    wait_edge(e);      chk("swr_dom_e",    32'(domain_rstn_o), 32'b010);
                       chk("swr_fetch_e",  32'(fetch_enable_o), 32'd0);
    wait_edge(e + 15); chk("swr_dom_e15",  32'(domain_rstn_o), 32'b010);
    wait_edge(e + 16); chk("swr_dom_e16",  32'(domain_rstn_o), 32'b111);
                       chk("swr_fetch_e16", 32'(fetch_enable_o), 32'd0);
    wait_edge(e + 17); chk("swr_fetch_e17", 32'(fetch_enable_o), 32'd1);

    // Re-request while held reloads the hold counter
    e = mn; sw_rst_req_i = 3'b010; step(); sw_rst_req_i = '0;
    repeat (4) step();
    sw_rst_req_i = 3'b010; step(); sw_rst_req_i = '0;
    wait_edge(e + 20); chk("reload_dom_e20", 32'(domain_rstn_o), 32'b101);
    wait_edge(e + 21); chk("reload_dom_e21", 32'(domain_rstn_o), 32'b111);

    // Lock loss in RUN
    step(); e = mn; fll_lock_i = 1'b0;
    wait_edge(e + 1); chk("lost_before", 32'(lock_lost_o), 32'd0);
    wait_edge(e + 2); chk("lost_set", 32'(lock_lost_o), 32'd1);
                      chk("lost_dom", 32'(domain_rstn_o), LOSS_RST ? 32'b000 : 32'b111);
                      chk("lost_state", 32'(state_o), LOSS_RST ? 32'd1 : 32'd3);
    fll_lock_i = 1'b1;
    wait_run();

    // Reset asserted during RELEASE after domain 0 is out
    rst_n = 1'b0; step(); rst_n = 1'b1;
    wait_edge(20); chk("mid_dom_e20", 32'(domain_rstn_o), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dom",   32'(domain_rstn_o), 32'd0);
    chk("async_fetch", 32'(fetch_enable_o), 32'd0);
    chk("async_lost",  32'(lock_lost_o), 32'd0);
    chk("async_state", 32'(state_o), 32'd0);
    step(); rst_n = 1'b1;
    boot_checks("boot2");

    // Lock timeout path
    rst_n = 1'b0; fll_lock_i = 1'b0; step(); rst_n = 1'b1;
    wait_edge(1023); chk("tmo_state_e1023", 32'(state_o), 32'd1);
                     chk("tmo_flag_e1023",  32'(lock_timeout_o), 32'd0);
    wait_edge(1024); chk("tmo_flag_e1024",  32'(lock_timeout_o), 32'd1);
                     chk("tmo_state_e1024", 32'(state_o), 32'd2);
    wait_edge(1040); chk("tmo_dom_e1040",   32'(domain_rstn_o), 32'b001);
    wait_edge(1072); chk("tmo_dom_e1072",   32'(domain_rstn_o), 32'b111);
                     chk("tmo_done_e1072",  32'(boot_done_o), 32'd1);
    fll_lock_i = 1'b1;

    // Test mode: combinational bypass
    step(); fetch_enable_i = 1'b1; testmode_i = 1'b1;
    #1 chk("tm_dom_hi",   32'(domain_rstn_o), 32'b111);
       chk("tm_fetch_hi", 32'(fetch_enable_o), 32'd1);
    fetch_enable_i = 1'b0;
    #1 chk("tm_fetch_lo", 32'(fetch_enable_o), 32'd0);
    step(); rst_n = 1'b0;
    #1 chk("tm_dom_lo", 32'(domain_rstn_o), 32'b000);
    step(); rst_n = 1'b1;
    #1 chk("tm_dom_back", 32'(domain_rstn_o), 32'b111);
    testmode_i = 1'b0; fetch_enable_i = 1'b1;
    wait_run();

    // Randomized run phase
    for (int c = 0; c < 3000; c++) begin
      step();
      fetch_enable_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NB; k++) r[k] = ($urandom_range(0, 15) == 0);
      sw_rst_req_i = r;
      if (fll_lock_i) fll_lock_i = ($urandom_range(0, 199) != 0);
      else            fll_lock_i = ($urandom_range(0, 19) == 0);
      testmode_i = ($urandom_range(0, 49) == 0);
    end
    step();
    sw_rst_req_i = '0; testmode_i = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
